// File: rtl/tage_update_sched.sv
// tage_update_sched
//   Owns the single index/update port of the TAGE predictor. Front-end lookups
//   are granted combinationally. Retired-branch updates wait in a small FIFO and
//   issue whenever no lookup claims the port. A lookup may pre-empt a waiting
//   update at most STARVE_MAX times in a row. When the execution domain changes,
//   the queue is drained. Every table entry is then scrubbed before any lookup
//   from the new domain is served.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   domain_i                 current execution domain
//   lookup_valid_i/_idx_i    fetch lookup request; lookup_ready_o = grant (same cycle)
//   upd_valid_i, upd_*_i     retire update offer; upd_ready_o = accepted this cycle
//   pred_*_o                 port to the predictor (index, update strobe, payload, domain)
//   scrub_busy_o             high while draining or scrubbing
//   q_count_o                number of queued updates
module tage_update_sched #(
  parameter int QDEPTH     = 4,
  parameter int SCRUB_N    = 256,
  parameter int STARVE_MAX = 8,
  parameter int DOMAIN_W   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DOMAIN_W-1:0]       domain_i,
  input  logic                      lookup_valid_i,
  input  logic [31:0]               lookup_idx_i,
  output logic                      lookup_ready_o,
  input  logic                      upd_valid_i,
  output logic                      upd_ready_o,
  input  logic [31:0]               upd_idx_i,
  input  logic                      upd_taken_i,
  input  logic                      upd_correct_i,
  input  logic [31:0]               upd_targ_i,
  output logic                      pred_update_en_o,
  output logic [31:0]               pred_idx_o,
  output logic                      pred_br_result_o,
  output logic                      pred_correct_o,
  output logic [31:0]               pred_targ_o,
  output logic [DOMAIN_W-1:0]       pred_domain_o,
  output logic                      scrub_busy_o,
  output logic [$clog2(QDEPTH):0]   q_count_o
);

  localparam int PTR_W    = $clog2(QDEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int SCRUB_W  = $clog2(SCRUB_N);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RUN, DRAIN, SCRUB} state_t;

  typedef struct packed {
    logic [31:0]         idx;
    logic                taken;
    logic                correct;
    logic [31:0]         targ;
    logic [DOMAIN_W-1:0] dom;
  } entry_t;

  state_t                state_reg, state_next;
  logic [SCRUB_W-1:0]    scrub_cnt_reg, scrub_cnt_next;
  logic [STARVE_W-1:0]   starve_reg, starve_next;
  logic [DOMAIN_W-1:0]   cur_dom_reg, cur_dom_next;

  entry_t                q_mem_reg [QDEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]      q_count_reg;

  logic   q_empty, q_full, push, pop;
  entry_t head, push_entry;

  assign q_empty    = (q_count_reg == '0);
  assign q_full     = (q_count_reg == CNT_W'(QDEPTH));
  assign head       = q_mem_reg[rd_ptr_reg];
  assign push       = upd_valid_i && upd_ready_o;
  assign push_entry = '{idx: upd_idx_i, taken: upd_taken_i, correct: upd_correct_i,
                        targ: upd_targ_i, dom: cur_dom_reg};
  assign q_count_o  = q_count_reg;

  always_comb begin
    state_next       = state_reg;
    scrub_cnt_next   = scrub_cnt_reg;
    starve_next      = starve_reg;
    cur_dom_next     = cur_dom_reg;
    pop              = 1'b0;
    lookup_ready_o   = 1'b0;
    upd_ready_o      = 1'b0;
    pred_update_en_o = 1'b0;
    pred_idx_o       = '0;
    pred_br_result_o = 1'b0;
    pred_correct_o   = 1'b0;
    pred_targ_o      = '0;
    pred_domain_o    = '0;
    scrub_busy_o     = 1'b0;

    // Outputs are qualified by rst_ni so they drop the moment reset asserts,
    // not just at the next clock edge.
    if (rst_ni) begin
      unique case (state_reg)
        RUN: begin
          pred_domain_o = cur_dom_reg;
          if (domain_i != cur_dom_reg) begin
            // Freeze the port for this cycle; the queue drains in DRAIN.
            state_next = DRAIN;
          end else begin
            upd_ready_o = !q_full;
            if (lookup_valid_i && !((starve_reg == STARVE_W'(STARVE_MAX)) && !q_empty)) begin
              lookup_ready_o = 1'b1;
              pred_idx_o     = lookup_idx_i;
              // The guard above keeps starve below STARVE_MAX here, so the
              // increment cannot overflow.
              if (!q_empty) starve_next = starve_reg + 1'b1;
            end else if (!q_empty) begin
              pred_update_en_o = 1'b1;
              pred_idx_o       = head.idx;
              pred_br_result_o = head.taken;
              pred_correct_o   = head.correct;
              pred_targ_o      = head.targ;
              pred_domain_o    = head.dom;
              pop              = 1'b1;
              starve_next      = '0;
            end
            if (q_empty) starve_next = '0;
          end
        end
        DRAIN: begin
          scrub_busy_o  = 1'b1;
          pred_domain_o = cur_dom_reg;
          starve_next   = '0;
          if (!q_empty) begin
            pred_update_en_o = 1'b1;
            pred_idx_o       = head.idx;
            pred_br_result_o = head.taken;
            pred_correct_o   = head.correct;
            pred_targ_o      = head.targ;
            pred_domain_o    = head.dom;
            pop              = 1'b1;
          end
          // Leave as soon as the last entry pops, without an idle cycle.
          if (q_empty || (q_count_reg == CNT_W'(1))) begin
            state_next     = SCRUB;
            scrub_cnt_next = '0;
          end
        end
        SCRUB: begin
          scrub_busy_o     = 1'b1;
          pred_update_en_o = 1'b1;
          pred_idx_o       = 32'(scrub_cnt_reg);
          pred_domain_o    = cur_dom_reg;
          if (scrub_cnt_reg == SCRUB_W'(SCRUB_N - 1)) begin
            state_next     = RUN;
            scrub_cnt_next = '0;
            cur_dom_next   = domain_i;
          end else begin
            scrub_cnt_next = scrub_cnt_reg + 1'b1;
          end
        end
        default: state_next = SCRUB;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= SCRUB;
      scrub_cnt_reg <= '0;
      starve_reg    <= '0;
      cur_dom_reg   <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      q_count_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      scrub_cnt_reg <= scrub_cnt_next;
      starve_reg    <= starve_next;
      cur_dom_reg   <= cur_dom_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      q_count_reg <= q_count_reg + 1'b1;
      else if (pop && !push) q_count_reg <= q_count_reg - 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) q_mem_reg[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: tb/tb_tage_update_sched.sv
module tb_tage_update_sched;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] domain;
  logic          lookup_valid;
  logic [31:0]   lookup_idx;
  logic          lookup_ready;
  logic          upd_valid;
  logic          upd_ready;
  logic [31:0]   upd_idx;
  logic          upd_taken;
  logic          upd_correct;
  logic [31:0]   upd_targ;
  logic          pred_update_en;
  logic [31:0]   pred_idx;
  logic          pred_br_result;
  logic          pred_correct;
  logic [31:0]   pred_targ;
  logic [DW-1:0] pred_domain;
  logic          scrub_busy;
  logic [2:0]    q_count;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] tb_dom;
  logic [67:0]   sb[$];
  logic [67:0]   got, exp_v;

  always #5 clk = ~clk;

  tage_update_sched #(.QDEPTH(4), .SCRUB_N(256), .STARVE_MAX(8), .DOMAIN_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .domain_i(domain),
    .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_ready_o(lookup_ready),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .upd_correct_i(upd_correct), .upd_targ_i(upd_targ),
    .pred_update_en_o(pred_update_en), .pred_idx_o(pred_idx), .pred_br_result_o(pred_br_result),
    .pred_correct_o(pred_correct), .pred_targ_o(pred_targ), .pred_domain_o(pred_domain),
    .scrub_busy_o(scrub_busy), .q_count_o(q_count)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Drive an update offer with random payload.
  task automatic offer_upd(input logic [31:0] idx);
    upd_valid   = 1'b1;
    upd_idx     = idx;
    upd_taken   = 1'($urandom);
    upd_correct = 1'($urandom);
    upd_targ    = $urandom;
  endtask

  // Record an accepted update in the scoreboard; call after outputs settle.
  task automatic note_push();
    if (upd_valid && upd_ready) begin
      sb.push_back({upd_idx, upd_taken, upd_correct, upd_targ, tb_dom});
      $display("push idx=%h taken=%0d correct=%0d targ=%h dom=%0d",
               upd_idx, upd_taken, upd_correct, upd_targ, tb_dom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; domain = '0; tb_dom = '0;
    lookup_valid = 1'b0; lookup_idx = '0; upd_valid = 1'b0;
    upd_idx = '0; upd_taken = 1'b0; upd_correct = 1'b0; upd_targ = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({pred_update_en, lookup_ready, upd_ready, pred_idx, q_count} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b lr=%b ur=%b idx=%h qc=%0d required all 0",
               pred_update_en, lookup_ready, upd_ready, pred_idx, q_count);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || pred_idx !== 32'(i) || scrub_busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_scrub: got en=%b idx=%h busy=%b required en=1 idx=%h busy=1",
                 pred_update_en, pred_idx, scrub_busy, 32'(i));
      end
    end
    @(negedge clk);
    lookup_valid = 1'b1; lookup_idx = 32'h40;
    #1;
    checks++;
    if (lookup_ready !== 1'b1 || pred_idx !== 32'h40 || pred_update_en !== 1'b0 || scrub_busy !== 1'b0) begin
      failures++;
      $display("FAIL first_lookup: got lr=%b idx=%h en=%b busy=%b required lr=1 idx=00000040 en=0 busy=0",
               lookup_ready, pred_idx, pred_update_en, scrub_busy);
    end
    $display("lookup idx=%h granted=%b", lookup_idx, lookup_ready);
  endtask

  task automatic test_update_order();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      lookup_valid = 1'b0;
      if (k <= 4) offer_upd(32'(k)); else upd_valid = 1'b0;
      #1;
      if (k <= 4) begin
        checks++;
        if (upd_ready !== 1'b1) begin
          failures++;
          $display("FAIL order_ready: got upd_ready=%b required 1", upd_ready);
        end
      end
      checks++;
      if (k == 1) begin
        if (pred_update_en !== 1'b0) begin
          failures++;
          $display("FAIL order_latency: got en=%b required 0 in accept cycle", pred_update_en);
        end
      end else if (pred_update_en !== 1'b1 || sb.size() == 0) begin
        failures++;
        $display("FAIL order_issue: got en=%b required 1 with entry pending", pred_update_en);
      end else begin
        got = {pred_idx, pred_br_result, pred_correct, pred_targ, pred_domain};
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL order_data: got %h required %h", got, exp_v);
        end
        $display("update idx=%h issued", pred_idx);
      end
      note_push();
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = 32'h100 + 32'(c);
      offer_upd(32'h11 + 32'(c));
      #1;
      checks++;
      if (lookup_ready !== 1'b1 || pred_idx !== lookup_idx || pred_update_en !== 1'b0) begin
        failures++;
        $display("FAIL full_lookup: got lr=%b idx=%h en=%b required lr=1 idx=%h en=0",
                 lookup_ready, pred_idx, pred_update_en, lookup_idx);
      end
      checks++;
      if (upd_ready !== (c < 4) || q_count !== 3'(c)) begin
        failures++;
        $display("FAIL full_ready: got ur=%b qc=%0d required ur=%0d qc=%0d",
                 upd_ready, q_count, (c < 4), c);
      end
      note_push();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      lookup_valid = 1'b0; upd_valid = 1'b0;
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || sb.size() == 0) begin
        failures++;
        $display("FAIL full_drain: got en=%b required 1", pred_update_en);
      end else begin
        got = {pred_idx, pred_br_result, pred_correct, pred_targ, pred_domain};
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL full_data: got %h required %h", got, exp_v);
        end
        $display("update idx=%h issued", pred_idx);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (q_count !== 3'd0 || pred_update_en !== 1'b0) begin
      failures++;
      $display("FAIL full_empty: got qc=%0d en=%b required 0 0", q_count, pred_update_en);
    end
  endtask

  task automatic test_starve();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = 32'h200 + 32'(c);
      if (c == 0) offer_upd(32'h10); else upd_valid = 1'b0;
      #1;
      checks++;
      if (c == 9) begin
        if (lookup_ready !== 1'b0 || pred_update_en !== 1'b1 || sb.size() == 0) begin
          failures++;
          $display("FAIL starve_force: got lr=%b en=%b required lr=0 en=1", lookup_ready, pred_update_en);
        end else begin
          got = {pred_idx, pred_br_result, pred_correct, pred_targ, pred_domain};
          exp_v = sb.pop_front();
          if (got !== exp_v) begin
            failures++;
            $display("FAIL starve_data: got %h required %h", got, exp_v);
          end
          $display("update idx=%h issued after starvation", pred_idx);
        end
      end else if (lookup_ready !== 1'b1 || pred_update_en !== 1'b0 || pred_idx !== lookup_idx) begin
        failures++;
        $display("FAIL starve_grant%0d: got lr=%b en=%b idx=%h required lr=1 en=0 idx=%h",
                 c, lookup_ready, pred_update_en, pred_idx, lookup_idx);
      end
      note_push();
    end
    lookup_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      lookup_valid = (c < 2);
      if (c < 3) offer_upd(32'h30 + 32'(c)); else upd_valid = 1'b0;
      #1;
      if (c >= 2) begin
        checks++;
        if (pred_update_en !== 1'b1 || sb.size() == 0) begin
          failures++;
          $display("FAIL pushpop_issue: got en=%b required 1", pred_update_en);
        end else begin
          got = {pred_idx, pred_br_result, pred_correct, pred_targ, pred_domain};
          exp_v = sb.pop_front();
          if (got !== exp_v) begin
            failures++;
            $display("FAIL pushpop_data: got %h required %h", got, exp_v);
          end
          $display("update idx=%h issued", pred_idx);
        end
      end
      if (c == 3) begin
        checks++;
        if (q_count !== 3'd2) begin
          failures++;
          $display("FAIL pushpop_count: got q_count=%0d required 2", q_count);
        end
      end
      note_push();
    end
  endtask

  task automatic test_domain_change();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = 32'h300;
      offer_upd(32'h50 + 32'(c));
      #1;
      note_push();
    end
    @(negedge clk);
    upd_valid = 1'b0; domain = 2'd1;
    #1;
    checks++;
    if (lookup_ready !== 1'b0 || pred_update_en !== 1'b0 || upd_ready !== 1'b0 || q_count !== 3'd3) begin
      failures++;
      $display("FAIL dom_stall: got lr=%b en=%b ur=%b qc=%0d required 0 0 0 3",
               lookup_ready, pred_update_en, upd_ready, q_count);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || lookup_ready !== 1'b0 || scrub_busy !== 1'b1 || sb.size() == 0) begin
        failures++;
        $display("FAIL dom_drain: got en=%b lr=%b busy=%b required 1 0 1",
                 pred_update_en, lookup_ready, scrub_busy);
      end else begin
        got = {pred_idx, pred_br_result, pred_correct, pred_targ, pred_domain};
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL dom_drain_data: got %h required %h", got, exp_v);
        end
        $display("drain update idx=%h dom=%0d", pred_idx, pred_domain);
      end
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || pred_idx !== 32'(i) || pred_domain !== 2'd0 ||
          pred_br_result !== 1'b0 || pred_correct !== 1'b0 || pred_targ !== 32'd0 || lookup_ready !== 1'b0) begin
        failures++;
        $display("FAIL dom_scrub: got en=%b idx=%h dom=%0d lr=%b required en=1 idx=%h dom=0 lr=0",
                 pred_update_en, pred_idx, pred_domain, lookup_ready, 32'(i));
      end
    end
    tb_dom = 2'd1;
    @(negedge clk);
    lookup_idx = 32'h301;
    #1;
    checks++;
    if (lookup_ready !== 1'b1 || pred_idx !== 32'h301 || pred_domain !== 2'd1 || scrub_busy !== 1'b0) begin
      failures++;
      $display("FAIL dom_resume: got lr=%b idx=%h dom=%0d busy=%b required 1 00000301 1 0",
               lookup_ready, pred_idx, pred_domain, scrub_busy);
    end
    $display("lookup idx=%h granted=%b dom=%0d", pred_idx, lookup_ready, pred_domain);
  endtask

  task automatic test_reset_mid_scrub();
    @(negedge clk);
    lookup_valid = 1'b0; domain = 2'd2;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (scrub_busy !== 1'b1 || pred_update_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_drain_idle: got busy=%b en=%b required 1 0", scrub_busy, pred_update_en);
    end
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || pred_idx !== 32'(i)) begin
        failures++;
        $display("FAIL mid_scrub: got en=%b idx=%h required 1 %h", pred_update_en, pred_idx, 32'(i));
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pred_update_en, lookup_ready, upd_ready, pred_idx, q_count} !== 38'd0) begin
      failures++;
      $display("FAIL async_reset: got en=%b idx=%h qc=%0d required all 0", pred_update_en, pred_idx, q_count);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      #1;
      checks++;
      if (pred_update_en !== 1'b1 || pred_idx !== 32'(i) || pred_domain !== 2'd0) begin
        failures++;
        $display("FAIL restart_scrub: got en=%b idx=%h dom=%0d required 1 %h 0",
                 pred_update_en, pred_idx, pred_domain, 32'(i));
      end
    end
    tb_dom = 2'd2;
    @(negedge clk);
    lookup_valid = 1'b1; lookup_idx = 32'h400;
    #1;
    checks++;
    if (lookup_ready !== 1'b1 || pred_domain !== 2'd2 || pred_idx !== 32'h400) begin
      failures++;
      $display("FAIL restart_resume: got lr=%b dom=%0d idx=%h required 1 2 00000400",
               lookup_ready, pred_domain, pred_idx);
    end
    $display("lookup idx=%h granted=%b dom=%0d", pred_idx, lookup_ready, pred_domain);
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_update_order();
    test_full();
    test_starve();
    test_push_pop();
    test_domain_change();
    test_reset_mid_scrub();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
